sieve_prime_reader: RTL and testbench
=====================================

# sieve_prime_reader

Read side of the prime sieve bitmap. Once the sieve engine finishes marking composites in the 1-bit RAM, this block scans read port B over addresses 2..N-1 and streams every address whose bit is 1 as a prime number on a valid/ready output. Scan pacing absorbs the RAM's 1-cycle read latency and downstream backpressure through a small output FIFO. It sits between the sieve RAM and the display/UART consumers.

## Interface
- N, 1000000: sieve bound; scanned range is 2..N-1
- AW, 20: address/data width; must satisfy 2^AW ≥ N
- FIFO_DEPTH, 4: output FIFO entries, power of two, ≥2
- clk  in  1  single clock; RAM port B shares it
- rst  in  1  synchronous, active-high reset
- start  in  1  level; driven by the sieve engine's over
- r_addr  out  AW  RAM port B address
- r_data  in  1  RAM port B data; valid 1 cycle after r_addr; 1 = prime, 0 = composite
- prime_valid  out  1  prime_data holds a prime
- prime_ready  in  1  consumer accepts
- prime_data  out  AW  prime value
- scan_busy  out  1  high in SCAN and DRAIN
- scan_done  out  1  high in DONE
- prime_count  out  AW  primes emitted in current scan (PRIME_COUNT_EN only)

## Operation
- FSM IDLE → SCAN → DRAIN → DONE → IDLE.
- IDLE: if start=1, load addr=2, clear prime_count, go to SCAN. If N≤2, go directly to DONE.
- SCAN: issue read at addr when fifo_count + inflight < FIFO_DEPTH; issue drives r_addr=addr, sets inflight, addr+1. After issuing N-1, go to DRAIN.
- Return path: one cycle after an issue, if r_data=1, push the registered address into the FIFO; if r_data=0, discard it. Inflight clears in the same cycle.
- DRAIN: wait for inflight=0 and FIFO empty, then go to DONE.
- DONE: hold scan_done=1 until start=0, then go to IDLE. A level-held start produces exactly one scan.
- start is ignored in SCAN and DRAIN.
- Transfer on prime_valid & prime_ready. prime_data/prime_valid present the FIFO head. prime_data is stable while valid and not ready.
- Push and pop in the same cycle on a full FIFO are not possible, because the issue credit rule reserves the slot.
- Addresses are AW bits unsigned. The addr counter never wraps, because it stops at N-1.

## Timing
- Reset values: r_addr=0, prime_valid=0, prime_data=0, scan_busy=0, scan_done=0, prime_count=0. FSM=IDLE, FIFO empty, inflight discarded.
- rst mid-scan aborts immediately. The next scan restarts from 2 with no stale output.
- start high at edge t: SCAN at t+1, first r_addr=2 at t+1, r_data for 2 at t+2. With prime_ready=1, first prime_valid at t+3 (FIFO push t+2, visible t+3).
- With prime_ready held high, one address issued per cycle, so a scan takes ≈N+3 cycles.
- prime_count increments in the cycle of each output transfer.
- scan_done rises the cycle after the last transfer, or after the last composite if the FIFO is already empty.

## Configuration
- PRIME_COUNT_EN defined: prime_count port and counter present, saturating at 2^AW-1.
- PRIME_COUNT_EN undefined: port and counter absent; all other behaviour identical.

## Structure
- Shared package sieve_pkg: AW default, N default, FSM state enum (IDLE, SCAN, DRAIN, DONE).
- Sub-module prime_fifo: synchronous FIFO with parameters DEPTH and WIDTH. Ports push/pop/din/dout/count/empty/full; same rst.

## Test plan
- N=30, RAM holds the correct sieve, prime_ready=1 → stream 2,3,5,7,11,13,17,19,23,29; then scan_done=1; prime_count=10.
- N=30, prime_ready random 50% → same 10 values in order, no loss/dup; prime_data stable while stalled.
- N=10, RAM all ones → stream 2..9 (8 values), r_addr never exceeds 9.
- N=2, start=1 → DONE within 2 cycles, prime_valid never asserts, prime_count=0.
- rst pulse after 5th prime (N=30) then start → stream restarts at 2, full 10 primes, no stale 13.
- start held high through DONE → single scan; dropping start returns to IDLE; a second rise rescans identically.

Source files
------------

// File: rtl/sieve_pkg.sv
// Shared definitions for the prime sieve read side: default sizes and scan FSM states.
package sieve_pkg;

  localparam int unsigned AW_DEF = 20;
  localparam int unsigned N_DEF  = 1000000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_e;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int unsigned occ_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sieve_prime_reader_if.sv
// RAM port B read path plus the prime valid/ready output stream.
interface sieve_prime_reader_if
  import sieve_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
);

  logic [AW-1:0] r_addr;
  logic          r_data;
  logic          prime_valid;
  logic          prime_ready;
  logic [AW-1:0] prime_data;

  modport master (
    output r_addr,
    input  r_data,
    output prime_valid,
    input  prime_ready,
    output prime_data
  );

  modport slave (
    input  r_addr,
    output r_data,
    input  prime_valid,
    output prime_ready,
    input  prime_data
  );

endinterface

// File: rtl/sieve_prime_reader_fifo.sv
// prime_fifo: small synchronous FIFO holding primes waiting for the consumer.
module prime_fifo
  import sieve_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = AW_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          din,
  output logic [WIDTH-1:0]          dout,
  output logic [occ_w(DEPTH)-1:0]   count,
  output logic                      empty,
  output logic                      full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = occ_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointer, occupancy and storage updates; pointers wrap since DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sieve_prime_reader.sv
// sieve_prime_reader: scans the sieve bitmap over 2..N-1 and streams addresses whose bit is 1.
// Optional: define PRIME_COUNT_EN to add the saturating prime_count output.
module sieve_prime_reader
  import sieve_pkg::*;
#(
  parameter int unsigned N          = N_DEF,
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  sieve_prime_reader_if.master bus,
  output logic                 scan_busy,
  output logic                 scan_done
`ifdef PRIME_COUNT_EN
  ,
  output logic [AW-1:0]        prime_count
`endif
);

  localparam int unsigned   CW         = occ_w(FIFO_DEPTH);
  localparam logic [AW-1:0] FIRST_ADDR = AW'(2);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(N - 1);
  localparam bit            EMPTY_SCAN = (N <= 2);

  scan_state_e   state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] ret_addr_q, ret_addr_d;
  logic          inflight_q, inflight_d;
  logic          scan_busy_q, scan_busy_d;
  logic          scan_done_q, scan_done_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty, fifo_full;
  logic          push, pop, issue, drain_clear;

  assign push = inflight_q & bus.r_data;
  assign pop  = bus.prime_valid & bus.prime_ready;

  // Issue only when the FIFO can still hold every read already in flight.
  assign issue = (state_q == SCAN) && !fifo_full &&
                 ((32'(fifo_count) + 32'(inflight_q)) < FIFO_DEPTH);

  // Nothing left to deliver once this edge retires the final pop (or a final composite).
  assign drain_clear = (!inflight_q || !bus.r_data) &&
                       (fifo_empty || ((fifo_count == CW'(1)) && pop));

  prime_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (ret_addr_q),
    .dout  (bus.prime_data),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign bus.prime_valid = ~fifo_empty;
  assign bus.r_addr      = addr_q;
  assign scan_busy       = scan_busy_q;
  assign scan_done       = scan_done_q;

  // Scan FSM next-state: address pacing, read tracking and status decode.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    ret_addr_d = ret_addr_q;
    inflight_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (EMPTY_SCAN) begin
            state_d = DONE;
          end else begin
            state_d = SCAN;
            addr_d  = FIRST_ADDR;
          end
        end
      end
      SCAN: begin
        if (issue) begin
          inflight_d = 1'b1;
          ret_addr_d = addr_q;
          if (addr_q == LAST_ADDR) state_d = DRAIN;
          else                     addr_d  = addr_q + AW'(1);
        end
      end
      DRAIN: begin
        if (drain_clear) state_d = DONE;
      end
      DONE: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    scan_busy_d = (state_d == SCAN) || (state_d == DRAIN);
    scan_done_d = (state_d == DONE);
  end

  // Scan FSM registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      ret_addr_q  <= '0;
      inflight_q  <= 1'b0;
      scan_busy_q <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      ret_addr_q  <= ret_addr_d;
      inflight_q  <= inflight_d;
      scan_busy_q <= scan_busy_d;
      scan_done_q <= scan_done_d;
    end
  end

`ifdef PRIME_COUNT_EN
  logic [AW-1:0] prime_count_q, prime_count_d;

  // Transfers in the current scan, cleared on scan start, saturating at all-ones.
  always_comb begin
    prime_count_d = prime_count_q;
    if ((state_q == IDLE) && start)       prime_count_d = '0;
    else if (pop && (prime_count_q != '1)) prime_count_d = prime_count_q + AW'(1);
  end

  // Prime counter register.
  always_ff @(posedge clk) begin
    if (rst) prime_count_q <= '0;
    else     prime_count_q <= prime_count_d;
  end

  assign prime_count = prime_count_q;
`endif

endmodule

// File: tb/tb_sieve_prime_reader.sv
// Testbench for sieve_prime_reader: three instances (N=30, N=10 all-ones RAM, N=2).
module tb_sieve_prime_reader;

  localparam int unsigned AW = 8;

  logic clk = 1'b0;
  logic rst;
  logic start_drv, ready_drv;
  int   sel;
  always #5 clk = ~clk;

  logic start0, start1, start2;
  logic busy0, busy1, busy2, done0, done1, done2;
  assign start0 = (sel == 0) ? start_drv : 1'b0;
  assign start1 = (sel == 1) ? start_drv : 1'b0;
  assign start2 = (sel == 2) ? start_drv : 1'b0;

  sieve_prime_reader_if #(.AW(AW)) if0 ();
  sieve_prime_reader_if #(.AW(AW)) if1 ();
  sieve_prime_reader_if #(.AW(AW)) if2 ();
  assign if0.prime_ready = ready_drv;
  assign if1.prime_ready = ready_drv;
  assign if2.prime_ready = ready_drv;

`ifdef PRIME_COUNT_EN
  logic [AW-1:0] cnt0, cnt1, cnt2;
`endif

  sieve_prime_reader #(.N(30), .AW(AW), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .bus(if0), .scan_busy(busy0), .scan_done(done0)
`ifdef PRIME_COUNT_EN
    , .prime_count(cnt0)
`endif
  );
  sieve_prime_reader #(.N(10), .AW(AW), .FIFO_DEPTH(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .bus(if1), .scan_busy(busy1), .scan_done(done1)
`ifdef PRIME_COUNT_EN
    , .prime_count(cnt1)
`endif
  );
  sieve_prime_reader #(.N(2), .AW(AW), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .bus(if2), .scan_busy(busy2), .scan_done(done2)
`ifdef PRIME_COUNT_EN
    , .prime_count(cnt2)
`endif
  );

  // Sieve RAMs with one-cycle read latency.
  bit ram0 [256];
  bit ram1 [256];
  bit ram2 [256];
  always @(posedge clk) begin
    if0.r_data <= ram0[if0.r_addr];
    if1.r_data <= ram1[if1.r_addr];
    if2.r_data <= ram2[if2.r_addr];
  end

  // Highest address ever presented by each instance.
  logic [AW-1:0] max0 = '0, max1 = '0;
  always @(posedge clk) begin
    if (if0.r_addr > max0) max0 <= if0.r_addr;
    if (if1.r_addr > max1) max1 <= if1.r_addr;
  end

  // Observation mux onto the selected instance.
  logic          obs_valid, obs_done, obs_busy;
  logic [AW-1:0] obs_data, obs_addr, obs_cnt;
  always_comb begin
    obs_valid = if0.prime_valid; obs_data = if0.prime_data; obs_addr = if0.r_addr;
    obs_done  = done0;           obs_busy = busy0;          obs_cnt  = '0;
`ifdef PRIME_COUNT_EN
    obs_cnt = cnt0;
`endif
    if (sel == 1) begin
      obs_valid = if1.prime_valid; obs_data = if1.prime_data; obs_addr = if1.r_addr;
      obs_done  = done1;           obs_busy = busy1;
`ifdef PRIME_COUNT_EN
      obs_cnt = cnt1;
`endif
    end else if (sel == 2) begin
      obs_valid = if2.prime_valid; obs_data = if2.prime_data; obs_addr = if2.r_addr;
      obs_done  = done2;           obs_busy = busy2;
`ifdef PRIME_COUNT_EN
      obs_cnt = cnt2;
`endif
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  logic [AW-1:0] got_q [$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Start a scan on instance s, collect transfers until scan_done, hold start, then release.
  task automatic run_scan(input int s, input bit rnd, input int hold, output int cyc_done);
    logic [AW-1:0] held;
    bit have_held, r;
    int stall_bad, hold_bad;
    got_q.delete();
    cyc_done = -1; have_held = 0; stall_bad = 0; hold_bad = 0; held = '0;
    @(negedge clk);
    sel = s; start_drv = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (obs_done) begin
        cyc_done = c + 1;
        break;
      end
      if (have_held && (!obs_valid || obs_data != held)) stall_bad++;
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ready_drv = r;
      if (obs_valid && r) begin
        got_q.push_back(obs_data);
        have_held = 0;
      end else if (obs_valid) begin
        have_held = 1;
        held = obs_data;
      end else begin
        have_held = 0;
      end
    end
    chk("stall_stable_violations", stall_bad, 0);
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      if (!obs_done || obs_valid || obs_busy) hold_bad++;
    end
    if (hold > 0) chk("held_start_single_scan_violations", hold_bad, 0);
    start_drv = 1'b0;
    ready_drv = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("done_drops_after_start_low", 32'(obs_done), 0);
  endtask

  typedef struct {
    int dut; bit rnd; int hold; int max_cyc; int exp_len;
    logic [9:0][7:0] exp_v;
  } vec_t;
  vec_t vt [7];

  task automatic set_vec(input int i, input int d, input bit rnd, input int hold,
                         input int mc, input int len, input logic [9:0][7:0] ev);
    vt[i].dut = d; vt[i].rnd = rnd; vt[i].hold = hold;
    vt[i].max_cyc = mc; vt[i].exp_len = len; vt[i].exp_v = ev;
  endtask

  initial begin
    logic [9:0][7:0] primes30, ones10;
    int cyc, n;
    primes30 = {8'd29, 8'd23, 8'd19, 8'd17, 8'd13, 8'd11, 8'd7, 8'd5, 8'd3, 8'd2};
    ones10   = {8'd0, 8'd0, 8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2};
    set_vec(0, 0, 1'b0, 0,  40,  10, primes30);
    set_vec(1, 0, 1'b1, 0,  300, 10, primes30);
    set_vec(2, 1, 1'b0, 0,  40,  8,  ones10);
    set_vec(3, 1, 1'b1, 0,  300, 8,  ones10);
    set_vec(4, 0, 1'b0, 10, 40,  10, primes30);
    set_vec(5, 0, 1'b0, 0,  40,  10, primes30);
    set_vec(6, 2, 1'b0, 0,  2,   0,  '0);

    for (int i = 0; i < 256; i++) begin
      ram0[i] = (i >= 2); ram1[i] = 1'b1; ram2[i] = 1'b1;
    end
    for (int i = 2; i < 16; i++)
      if (ram0[i]) for (int j = i * i; j < 256; j += i) ram0[j] = 1'b0;

    sel = 0; start_drv = 1'b0; ready_drv = 1'b0; rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_prime_valid", 32'(obs_valid), 0);
    chk("reset_prime_data", 32'(obs_data), 0);
    chk("reset_r_addr", 32'(obs_addr), 0);
    chk("reset_scan_busy", 32'(obs_busy), 0);
    chk("reset_scan_done", 32'(obs_done), 0);
    chk("reset_prime_count", 32'(obs_cnt), 0);
    rst = 1'b0;
    @(negedge clk);

    // First-prime latency: busy and r_addr=2 one edge after start, valid after the third.
    ready_drv = 1'b1; sel = 0; start_drv = 1'b1;
    @(negedge clk);
    chk("lat_busy_t1", 32'(obs_busy), 1);
    chk("lat_r_addr_t1", 32'(obs_addr), 2);
    chk("lat_valid_t1", 32'(obs_valid), 0);
    @(negedge clk);
    chk("lat_valid_t2", 32'(obs_valid), 0);
    @(negedge clk);
    chk("lat_valid_t3", 32'(obs_valid), 1);
    chk("lat_data_t3", 32'(obs_data), 2);
    n = 0;
    for (int c = 0; c < 100 && !obs_done; c++) begin
      @(negedge clk);
      n = c + 1;
    end
    chk("lat_scan_done_reached", 32'(obs_done), 1);
    chk("lat_scan_not_too_slow", 32'(n <= 40), 1);
    start_drv = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven scans.
    for (int v = 0; v < 7; v++) begin
      run_scan(vt[v].dut, vt[v].rnd, vt[v].hold, cyc);
      chk($sformatf("v%0d_done_in_budget(cyc=%0d)", v, cyc),
          32'(cyc > 0 && cyc <= vt[v].max_cyc), 1);
      chk($sformatf("v%0d_len", v), got_q.size(), vt[v].exp_len);
      for (int i = 0; i < vt[v].exp_len; i++)
        chk($sformatf("v%0d_prime[%0d]", v, i),
            (i < got_q.size()) ? int'(got_q[i]) : -1, int'(vt[v].exp_v[i]));
`ifdef PRIME_COUNT_EN
      chk($sformatf("v%0d_prime_count", v), 32'(obs_cnt), vt[v].exp_len);
`endif
    end
    chk("n30_max_r_addr", 32'(max0), 29);
    chk("n10_max_r_addr", 32'(max1), 9);

    // Reset after the 5th transfer, then a clean rescan from 2.
    @(negedge clk);
    sel = 0; ready_drv = 1'b1; start_drv = 1'b1; n = 0;
    for (int c = 0; c < 100 && n < 5; c++) begin
      @(negedge clk);
      if (obs_valid) n++;
    end
    chk("rst_mid_five_transfers", n, 5);
    @(negedge clk);
    rst = 1'b1; start_drv = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", 32'(obs_valid), 0);
    chk("rst_mid_busy", 32'(obs_busy), 0);
    chk("rst_mid_r_addr", 32'(obs_addr), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(obs_valid), 0);
    run_scan(0, 1'b0, 0, cyc);
    chk("post_rst_done_reached", 32'(cyc > 0), 1);
    chk("post_rst_len", got_q.size(), 10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("post_rst_prime[%0d]", i),
          (i < got_q.size()) ? int'(got_q[i]) : -1, int'(primes30[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
